// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline-stage register with valid/ready handshake.
// Carries a control bundle (zeroed whenever its entry is not valid) and a data
// bundle (held across bubbles). With SKID=1 a second entry absorbs one
// in-flight input so that in_ready_o comes straight from a flop.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  // Main register drives the outputs; skid register holds the second entry.
  logic              main_valid_reg, main_valid_next;
  logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg,  main_data_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;

  logic accept;
  logic deliver;
  logic drop;

  assign accept  = in_valid_i & in_ready_o;
  assign deliver = main_valid_reg & out_ready_i;
  // Stopping the CPU behaves exactly like a continuous flush.
  assign drop    = flush_i | ~start_i;

  // Next-state for EMPTY / FULL / SKID occupancy; ctrl is zeroed on every invalidation.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    skid_data_next  = skid_data_reg;
    if (drop) begin
      // Data registers deliberately keep their contents to avoid toggling.
      main_valid_next = 1'b0;
      main_ctrl_next  = '0;
      skid_valid_next = 1'b0;
      skid_ctrl_next  = '0;
    end else if (!main_valid_reg) begin
      if (accept) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = ctrl_i;
        main_data_next  = data_i;
      end
    end else if (!skid_valid_reg) begin
      if (accept && deliver) begin
        main_ctrl_next = ctrl_i;
        main_data_next = data_i;
      end else if (accept && (SKID != 0)) begin
        skid_valid_next = 1'b1;
        skid_ctrl_next  = ctrl_i;
        skid_data_next  = data_i;
      end else if (deliver) begin
        main_valid_next = 1'b0;
        main_ctrl_next  = '0;
      end
    end else begin
      // Both entries held: in_ready_o is low, so only draining can happen.
      if (deliver) begin
        main_ctrl_next  = skid_ctrl_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
        skid_ctrl_next  = '0;
      end
    end
  end

  // Entry registers; reset clears everything including data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_reg <= 1'b0;
      main_ctrl_reg  <= '0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_ctrl_reg  <= '0;
      skid_data_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      skid_data_reg  <= skid_data_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic ready_reg;

      // Ready is a flop copy of "next state is not SKID"; reset and stop still force it low.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ready_reg <= 1'b0;
        end else begin
          ready_reg <= ~skid_valid_next;
        end
      end

      assign in_ready_o = ready_reg & start_i & ~rst_i;
    end else begin : g_noskid
      // Single entry: can take a new item when empty or when the held one leaves now.
      assign in_ready_o = ~rst_i & start_i & (~main_valid_reg | out_ready_i);
    end
  endgenerate

  assign out_valid_o = main_valid_reg;
  assign ctrl_o      = main_ctrl_reg;
  assign data_o      = main_data_reg;
  assign occ_o       = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

  // Structural invariants of the stage.
  a_ctrl_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (ctrl_o != '0) |-> out_valid_o);
  a_occ_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    occ_o <= 2'(1 + SKID));
  a_full_not_ready : assert property (@(posedge clk_i) disable iff (rst_i)
    (occ_o == 2'd2) |-> !in_ready_o);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (SKID=1) plus a random back-pressure
// scoreboard run on a SKID=0 instance.
module tb_pipe_stage_reg;

  logic         clk;
  // SKID=1 instance signals
  logic         rst, start, flush, in_valid, out_ready;
  logic [7:0]   ctrl_in;
  logic [127:0] data_in;
  logic         in_ready, out_valid;
  logic [7:0]   ctrl_out;
  logic [127:0] data_out;
  logic [1:0]   occ;
  // SKID=0 instance signals
  logic         rst0, in_valid0, out_ready0;
  logic [7:0]   ctrl_in0;
  logic [31:0]  data_in0;
  logic         in_ready0, out_valid0;
  logic [7:0]   ctrl_out0;
  logic [31:0]  data_out0;
  logic [1:0]   occ0;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(8), .SKID(1)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .ctrl_i(ctrl_in), .data_i(data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .ctrl_o(ctrl_out),
    .data_o(data_out), .occ_o(occ)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .start_i(1'b1), .flush_i(1'b0),
    .in_valid_i(in_valid0), .in_ready_o(in_ready0), .ctrl_i(ctrl_in0), .data_i(data_in0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .ctrl_o(ctrl_out0),
    .data_o(data_out0), .occ_o(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [127:0] d);
    in_valid = v;
    ctrl_in  = c;
    data_in  = d;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] c,
                         input logic [127:0] d, input logic [1:0] o);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".ctrl"},  ctrl_out,  c);
    chk({tag, ".data"},  data_out,  d);
    chk({tag, ".occ"},   occ,       o);
    $display("step %s: valid=%0d ctrl=%0h data=%0h occ=%0d ready=%0d",
             tag, out_valid, ctrl_out, data_out, occ, in_ready);
  endtask

  initial begin
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [31:0] m_data;
    logic [31:0] send_cnt;
    logic [31:0] recv_cnt;
    logic        exp_ready, acc, del;

    rst = 1'b1; start = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; ctrl_in = '0; data_in = '0;
    rst0 = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b0; ctrl_in0 = '0; data_in0 = '0;

    // Reset for two cycles
    tick(); tick();
    chk_out("reset", 1'b0, 8'h00, 128'h0, 2'd0);
    chk("reset.ready", in_ready, 1'b0);
    rst = 1'b0; #1;
    chk("post_reset.ready", in_ready, 1'b0);
    tick();
    chk("post_reset2.ready", in_ready, 1'b1);

    // Streaming 1..4 with downstream always ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 128'(i));
      tick();
      chk_out($sformatf("stream%0d", i), 1'b1, 8'(i), 128'(i), 2'd1);
      chk($sformatf("stream%0d.ready", i), in_ready, 1'b1);
    end
    drive(1'b0, 8'h00, 128'h0);
    tick();
    chk_out("stream_drain", 1'b0, 8'h00, 128'h4, 2'd0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 128'hAA);
    tick();
    chk_out("bp_a", 1'b1, 8'hAA, 128'hAA, 2'd1);
    chk("bp_a.ready", in_ready, 1'b1);
    drive(1'b1, 8'hBB, 128'hBB);
    tick();
    chk_out("bp_b", 1'b1, 8'hAA, 128'hAA, 2'd2);
    chk("bp_b.ready", in_ready, 1'b0);
    drive(1'b1, 8'hCC, 128'hCC);
    tick();
    chk_out("bp_hold", 1'b1, 8'hAA, 128'hAA, 2'd2);
    chk("bp_hold.ready", in_ready, 1'b0);
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 128'h0);
    tick();
    chk_out("bp_rel1", 1'b1, 8'hBB, 128'hBB, 2'd1);
    tick();
    chk_out("bp_rel2", 1'b0, 8'h00, 128'hBB, 2'd0);

    // Flush with two entries held and a same-cycle input
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 128'h11);
    tick();
    drive(1'b1, 8'h22, 128'h22);
    tick();
    chk_out("fl_fill", 1'b1, 8'h11, 128'h11, 2'd2);
    flush = 1'b1;
    drive(1'b1, 8'h33, 128'h33);
    tick();
    chk_out("flush", 1'b0, 8'h00, 128'h11, 2'd0);
    flush = 1'b0;
    drive(1'b0, 8'h00, 128'h0);
    chk("flush.ready", in_ready, 1'b1);
    tick();
    chk_out("flush_after", 1'b0, 8'h00, 128'h11, 2'd0);

    // start_i low for three cycles during streaming
    out_ready = 1'b1;
    drive(1'b1, 8'h40, 128'h40);
    tick();
    chk_out("run", 1'b1, 8'h40, 128'h40, 2'd1);
    start = 1'b0;
    drive(1'b1, 8'h41, 128'h41);
    chk("stop.ready_now", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("stop%0d", i), 1'b0, 8'h00, 128'h40, 2'd0);
      chk($sformatf("stop%0d.ready", i), in_ready, 1'b0);
    end
    start = 1'b1;
    drive(1'b0, 8'h00, 128'h0);
    chk("restart.ready", in_ready, 1'b1);
    tick();
    chk_out("restart_idle", 1'b0, 8'h00, 128'h40, 2'd0);
    drive(1'b1, 8'h50, 128'h50);
    tick();
    chk_out("restart_data", 1'b1, 8'h50, 128'h50, 2'd1);
    drive(1'b0, 8'h00, 128'h0);
    tick();

    // Reset pulse with two entries held
    out_ready = 1'b0;
    drive(1'b1, 8'h61, 128'h61);
    tick();
    drive(1'b1, 8'h62, 128'h62);
    tick();
    chk_out("rst_fill", 1'b1, 8'h61, 128'h61, 2'd2);
    rst = 1'b1;
    drive(1'b0, 8'h00, 128'h0);
    tick();
    chk_out("rst_mid", 1'b0, 8'h00, 128'h0, 2'd0);
    chk("rst_mid.ready", in_ready, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_out("rst_after1", 1'b0, 8'h00, 128'h0, 2'd0);
    tick();
    chk_out("rst_after2", 1'b0, 8'h00, 128'h0, 2'd0);

    // SKID=0 random handshake against a single-entry scoreboard model
    rst0 = 1'b0;
    m_valid = 1'b0; m_ctrl = '0; m_data = '0;
    send_cnt = 32'd1; recv_cnt = 32'd1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      in_valid0  = ($urandom_range(0, 3) != 0);
      out_ready0 = ($urandom_range(0, 2) != 0);
      data_in0   = send_cnt;
      ctrl_in0   = send_cnt[7:0] | 8'h01;
      #1;
      exp_ready = !m_valid || out_ready0;
      acc = in_valid0 && exp_ready;
      del = m_valid && out_ready0;
      chk("s0.ready", in_ready0, exp_ready);
      chk("s0.valid", out_valid0, m_valid);
      chk("s0.ctrl", ctrl_out0, m_ctrl);
      if (del) begin
        chk("s0.order", data_out0, recv_cnt);
        recv_cnt++;
      end
      if (acc) begin
        m_valid = 1'b1;
        m_ctrl  = send_cnt[7:0] | 8'h01;
        m_data  = send_cnt;
        send_cnt++;
      end else if (del) begin
        m_valid = 1'b0;
        m_ctrl  = '0;
      end
      tick();
      chk("s0.occ", occ0, {1'b0, m_valid});
      if (m_valid) chk("s0.data", data_out0, m_data);
    end
    $display("skid0 random: sent=%0d received=%0d", send_cnt - 1, recv_cnt - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
